multicycle_ctrl_m: RTL
======================

# multicycle_ctrl_m

Multi-cycle sequencer for the LEGv8 subset datapath, the successor to the single-cycle processor top. It owns the PC, the instruction register and the ALU-result/memory-data registers. It drives the existing register file, ALU and memories through handshaked or strobed ports, so each instruction takes 3–5 cycles plus memory wait states. Data width, PC width and reset vector are parametrised, and memories may have any latency.

## Interface
Parameters:
- DATA_W, 32, datapath width (32 or 64)
- PC_W, 32, program-counter width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (current PC)
- imem_ack  in  1  fetch complete; imem_data valid this cycle
- imem_data  in  32  instruction word
- rf_rd1 / rf_rd2  out  5 each  read addresses; rd2 = Rm for R-type, Rt for STUR/CBZ
- rf_data1 / rf_data2  in  DATA_W each  read data
- rf_we  out  1  register write strobe, one cycle
- rf_wa  out  5  write address
- rf_wdata  out  DATA_W  write data
- alu_ctl  out  4  0010 add, 0110 sub, 0000 and, 0001 orr, 0111 pass-B
- alu_a / alu_b  out  DATA_W each  ALU operands
- alu_result  in  DATA_W  ALU output
- alu_zero  in  1  ALU zero flag
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store
- dmem_addr  out  DATA_W  address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  access complete; dmem_rdata valid on loads
- dmem_rdata  in  DATA_W  load data
- halted  out  1  core stopped
- instret  out  32  retired-instruction count

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: assert imem_req with imem_addr = PC. On imem_ack, latch IR, set ir_pc = PC and PC = PC+4, then go to DECODE.
- DECODE: drive rf_rd1/rf_rd2 from IR. Latch A/B from rf_data; a source register of 31 (XZR) reads as 0. Sign-extend the immediate:
  - LDUR/STUR: IR[20:12], 9 bits
  - CBZ: IR[23:5]<<2
  - B: IR[25:0]<<2
- Opcodes:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
  - LDUR 11111000010, STUR 11111000000
  - CBZ 10110100 (IR[31:24]), B 000101 (IR[31:26])
- EXEC by instruction:
  - R-type: alu_a=A, alu_b=B; latch alu_result into ALUOut; go to WB.
  - LDUR/STUR: alu_ctl add, alu_b=imm; latch address into ALUOut; go to MEM.
  - CBZ: alu_ctl pass-B, alu_b=B. If alu_zero, set PC = ir_pc+imm. Retire; go to FETCH.
  - B: PC = ir_pc+imm. Retire; go to FETCH.
- MEM: hold dmem_req with dmem_addr = ALUOut (dmem_wdata = B for STUR) until dmem_ack.
  - LDUR: latch dmem_rdata into MDR; go to WB.
  - STUR: retire; go to FETCH.
- WB: rf_we = 1 for exactly one cycle with rf_wa = Rd and rf_wdata = ALUOut (R-type) or MDR (LDUR). Writes to register 31 are suppressed (rf_we stays 0). Retire; go to FETCH.
- Retire: instret increments by 1 and wraps at 2^32.
- Arithmetic: PC adds are modulo 2^PC_W; the offset is sign-extended to PC_W before the add.

## Timing
- Reset values: PC=RESET_PC, state FETCH, IR=0, instret=0, halted=0. All strobes (imem_req, dmem_req, dmem_we, rf_we) are 0.
- Reset asserted mid-operation forces these values immediately. Any in-flight request is abandoned, and a late ack is ignored.
- imem_req/dmem_req and their address/data are stable from assertion until the ack cycle inclusive. A request deasserts in the cycle after its ack.
- An ack is accepted in the first request cycle, so the zero-wait fetch is 1 cycle.
- An ack received while no request is outstanding is ignored.
- Zero-wait cycle counts: R-type 4, LDUR 5, STUR 4, CBZ/B 3. Each memory wait cycle adds 1.
- EXEC latches the ALU output at the end of the cycle, so the ALU must be combinational.

## Configuration
- ILLEGAL_TRAP_EN defined: an unrecognised opcode in DECODE enters HALT. PC stays at ir_pc+4, halted=1, and the core stays in HALT until reset, with no retire.
- ILLEGAL_TRAP_EN undefined: an unrecognised opcode is a NOP. It retires and returns to FETCH, and halted stays 0.

## Structure
- Shared package multicycle_pkg_m holds the state encoding, opcode constants, alu_ctl codes and the XZR index (31).
- One sub-module, imm_gen_m: combinational immediate extraction and sign-extension, parametrised by PC_W/DATA_W.

## Test plan
- Reset PC=0; memory holds ADD X1,X2,X3 with X2=5, X3=7, zero-wait → rf_we pulses at cycle 4 with rf_wa=1, rf_wdata=12; instret=1; PC=4.
- LDUR X4,[X5,#-8] with X5=0x20 and a 2-cycle dmem_ack delay → dmem_addr=0x18; rf_wdata=dmem_rdata at cycle 7.
- CBZ X6 offset +3 at PC=0x10: with X6=0 → next fetch at 0x1C; with X6=1 → next fetch at 0x14.
- B offset −4 at PC=0x40 → next fetch at 0x30; ADD X31,… → rf_we never asserts.
- Reset during MEM wait of STUR → dmem_req drops immediately; a later dmem_ack is ignored; fetch restarts at RESET_PC.
- Opcode 0xFFFFFFFF: with ILLEGAL_TRAP_EN → halted=1 and imem_req stays 0; without it → instret increments and the next fetch is at PC+4.

Source files
------------

// File: rtl/multicycle_pkg_m.sv
// Shared definitions for the multi-cycle LEGv8 sequencer: FSM states, opcode
// constants, ALU control codes and opcode classification helpers.
package multicycle_pkg_m;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_ORR,
        OP_LDUR,
        OP_STUR,
        OP_CBZ,
        OP_B,
        OP_ILL
    } op_t;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [5:0]  OPC_B    = 6'b000101;

    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_ORR    = 4'b0001;
    localparam logic [3:0] ALU_PASS_B = 4'b0111;

    localparam logic [4:0] XZR = 5'd31;

    // Classifies IR[31:21]; CBZ and B are matched on their shorter prefixes.
    function automatic op_t decode_op(input logic [10:0] opc);
        op_t op;
        op = OP_ILL;
        if (opc == OPC_ADD)               op = OP_ADD;
        else if (opc == OPC_SUB)          op = OP_SUB;
        else if (opc == OPC_AND)          op = OP_AND;
        else if (opc == OPC_ORR)          op = OP_ORR;
        else if (opc == OPC_LDUR)         op = OP_LDUR;
        else if (opc == OPC_STUR)         op = OP_STUR;
        else if (opc[10:3] == OPC_CBZ)    op = OP_CBZ;
        else if (opc[10:5] == OPC_B)      op = OP_B;
        return op;
    endfunction

    function automatic logic [3:0] alu_ctl_of(input op_t op);
        logic [3:0] ctl;
        case (op)
            OP_SUB:  ctl = ALU_SUB;
            OP_AND:  ctl = ALU_AND;
            OP_ORR:  ctl = ALU_ORR;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/imm_gen_m.sv
// Immediate extraction: 9-bit load/store offset (data width) and the
// word-scaled CBZ/B branch offset (PC width), both sign-extended.
module imm_gen_m
    import multicycle_pkg_m::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic [31:0]       ir,
    output logic [DATA_W-1:0] imm_mem,
    output logic [PC_W-1:0]   imm_br
);

    assign imm_mem = {{(DATA_W-9){ir[20]}}, ir[20:12]};

    always_comb begin
        if (ir[31:26] == OPC_B) begin
            imm_br = {{(PC_W-28){ir[25]}}, ir[25:0], 2'b00};
        end else begin
            imm_br = {{(PC_W-21){ir[23]}}, ir[23:5], 2'b00};
        end
    end

endmodule

// File: rtl/multicycle_ctrl_m.sv
// Multi-cycle LEGv8 sequencer owning PC, IR, A/B, ALUOut and MDR.
// Define ILLEGAL_TRAP_EN to halt on unrecognised opcodes (default: NOP).
module multicycle_ctrl_m
    import multicycle_pkg_m::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic [4:0]        rf_rd1,
    output logic [4:0]        rf_rd2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    output logic              rf_we,
    output logic [4:0]        rf_wa,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [3:0]        alu_ctl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              halted,
    output logic [31:0]       instret,
    output state_t            dbg_state
);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc, ir_pc;
    logic [31:0]       ir;
    logic [DATA_W-1:0] a_q, b_q, alu_out, mdr;
    logic [31:0]       instret_q;

    logic [DATA_W-1:0] imm_mem;
    logic [PC_W-1:0]   imm_br;
    op_t               op;
    logic              is_rtype;

    logic ld_ir, ld_ab, ld_alu_out, ld_mdr, br_take, retire;

    imm_gen_m #(.DATA_W(DATA_W), .PC_W(PC_W)) u_imm_gen (
        .ir      (ir),
        .imm_mem (imm_mem),
        .imm_br  (imm_br)
    );

    assign op        = decode_op(ir[31:21]);
    assign is_rtype  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
    assign imem_addr = pc;
    assign halted    = (state_q == S_HALT);
    assign instret   = instret_q;
    assign dbg_state = state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        rf_rd1     = ir[9:5];
        rf_rd2     = is_rtype ? ir[20:16] : ir[4:0];
        rf_we      = 1'b0;
        rf_wa      = ir[4:0];
        rf_wdata   = (op == OP_LDUR) ? mdr : alu_out;
        alu_ctl    = ALU_ADD;
        alu_a      = a_q;
        alu_b      = b_q;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = alu_out;
        dmem_wdata = b_q;
        ld_ir      = 1'b0;
        ld_ab      = 1'b0;
        ld_alu_out = 1'b0;
        ld_mdr     = 1'b0;
        br_take    = 1'b0;
        retire     = 1'b0;

        case (state_q)
            S_FETCH: begin
                // Strobes must read 0 while reset is held, even though the state is FETCH.
                imem_req = !reset;
                if (imem_ack) begin
                    ld_ir   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ld_ab = 1'b1;
                if (op == OP_ILL) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    retire  = 1'b1;
                    state_d = S_FETCH;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                        alu_ctl    = alu_ctl_of(op);
                        ld_alu_out = 1'b1;
                        state_d    = S_WB;
                    end
                    OP_LDUR, OP_STUR: begin
                        alu_b      = imm_mem;
                        ld_alu_out = 1'b1;
                        state_d    = S_MEM;
                    end
                    OP_CBZ: begin
                        alu_ctl = ALU_PASS_B;
                        br_take = alu_zero;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_B: begin
                        br_take = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op == OP_STUR);
                if (dmem_ack) begin
                    if (op == OP_LDUR) begin
                        ld_mdr  = 1'b1;
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we   = (ir[4:0] != XZR);
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            ir_pc     <= RESET_PC;
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            instret_q <= '0;
        end else begin
            if (ld_ir) begin
                ir    <= imem_data;
                ir_pc <= pc;
                pc    <= pc + PC_W'(4);
            end else if (br_take) begin
                pc <= ir_pc + imm_br;
            end
            if (ld_ab) begin
                a_q <= (rf_rd1 == XZR) ? '0 : rf_data1;
                b_q <= (rf_rd2 == XZR) ? '0 : rf_data2;
            end
            if (ld_alu_out) alu_out <= alu_result;
            if (ld_mdr)     mdr <= dmem_rdata;
            if (retire)     instret_q <= instret_q + 32'd1;
        end
    end

endmodule
